// File: rtl/rx_hex_parser.sv
// Assembles ASCII hex tokens from UART byte strobes into words behind a one-entry valid/ready register; `RX_HEX_LOWER_EN adds a-f digits.
// Latency: terminator to word_vld is 1 cycle; never backpressures the receiver, a word completing into a full register is dropped.
module rx_hex_parser #(
  parameter int MAX_DIGITS = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rx_vld,
  input  logic [7:0]              rx_data,
  input  logic                    word_rdy,
  output logic                    word_vld,
  output logic [4*MAX_DIGITS-1:0] word,
  output logic [3:0]              word_len,
  output logic                    err,
  output logic                    drop
);

  localparam int         W       = 4 * MAX_DIGITS;
  localparam logic [3:0] CNT_MAX = 4'(MAX_DIGITS);

  typedef enum logic [1:0] {S_IDLE, S_DIGIT, S_ERR} state_t;

  state_t       state_q, state_d;
  logic [W-1:0] acc_q, acc_d, word_q, word_d;
  logic [3:0]   cnt_q, cnt_d, len_q, len_d;
  logic         vld_q, vld_d, err_q, err_d, drop_q, drop_d;
  logic         is_digit, is_term, complete;
  logic [3:0]   nib;

  always_comb begin
    is_digit = 1'b0;
    nib      = 4'd0;
    if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
      is_digit = 1'b1;
      nib      = rx_data[3:0];
    end else if (rx_data >= 8'h41 && rx_data <= 8'h46) begin
      is_digit = 1'b1;
      nib      = rx_data[3:0] + 4'd9;
`ifdef RX_HEX_LOWER_EN
    end else if (rx_data >= 8'h61 && rx_data <= 8'h66) begin
      is_digit = 1'b1;
      nib      = rx_data[3:0] + 4'd9;
`endif
    end
    is_term = (rx_data == 8'h20) || (rx_data == 8'h0D) || (rx_data == 8'h0A);
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    err_d    = 1'b0;
    drop_d   = 1'b0;
    word_d   = word_q;
    len_d    = len_q;
    vld_d    = vld_q & ~word_rdy;
    complete = 1'b0;

    if (rx_vld) begin
      case (state_q)
        S_IDLE: begin
          if (is_digit) begin
            acc_d   = W'(nib);
            cnt_d   = 4'd1;
            state_d = S_DIGIT;
          end else if (!is_term) begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end
        end
        S_DIGIT: begin
          if (is_digit && cnt_q != CNT_MAX) begin
            acc_d = {acc_q[W-5:0], nib};
            cnt_d = cnt_q + 4'd1;
          end else if (is_term) begin
            complete = 1'b1;
            acc_d    = '0;
            cnt_d    = 4'd0;
            state_d  = S_IDLE;
          end else begin
            // overflow and illegal bytes both poison the token
            err_d   = 1'b1;
            state_d = S_ERR;
          end
        end
        default: begin
          if (is_term) begin
            acc_d   = '0;
            cnt_d   = 4'd0;
            state_d = S_IDLE;
          end
        end
      endcase
    end

    if (complete) begin
      if (!vld_q || word_rdy) begin
        word_d = acc_q;
        len_d  = cnt_q;
        vld_d  = 1'b1;
      end else begin
        drop_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= 4'd0;
      word_q  <= '0;
      len_q   <= 4'd0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      len_q   <= len_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
    end
  end

  assign word_vld = vld_q;
  assign word     = word_q;
  assign word_len = len_q;
  assign err      = err_q;
  assign drop     = drop_q;

endmodule

// File: tb/tb_rx_hex_parser.sv
// Scoreboard bench for rx_hex_parser: token-level reference model feeds expected words/pulses to queues, a monitor pops and compares.
module tb_rx_hex_parser;

  localparam int MAXD = 8;
  localparam int W    = 4 * MAXD;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         rx_vld = 1'b0;
  logic [7:0]   rx_data = 8'h00;
  logic         word_rdy = 1'b0;
  logic         word_vld;
  logic [W-1:0] word;
  logic [3:0]   word_len;
  logic         err;
  logic         drop;

  rx_hex_parser #(.MAX_DIGITS(MAXD)) dut (
    .clk(clk), .rst_n(rst_n), .rx_vld(rx_vld), .rx_data(rx_data),
    .word_rdy(word_rdy), .word_vld(word_vld), .word(word), .word_len(word_len),
    .err(err), .drop(drop)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] val;
    int           len;
  } wexp_t;

  wexp_t wq[$];
  int    errq[$];
  int    dropq[$];
  int    n_cmp = 0;
  int    n_fail = 0;

  // reference model: the token in progress as a list of digit values
  int    tok[$];
  bit    m_bad  = 1'b0;
  bit    m_held = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int digit_val(input logic [7:0] b);
    if (b >= "0" && b <= "9") return int'(b) - 48;
    if (b >= "A" && b <= "F") return int'(b) - 55;
`ifdef RX_HEX_LOWER_EN
    if (b >= "a" && b <= "f") return int'(b) - 87;
`endif
    return -1;
  endfunction

  task automatic step(input bit v, input logic [7:0] d, input bit r);
    int          n;
    bit          done;
    wexp_t       e;
    @(posedge clk);
    #1;
    rx_vld   = v;
    rx_data  = d;
    word_rdy = r;
    done     = 1'b0;
    if (v) begin
      n = digit_val(d);
      if (n >= 0) begin
        if (!m_bad) begin
          if (tok.size() == MAXD) begin
            errq.push_back(cyc + 1);
            m_bad = 1'b1;
            tok.delete();
          end else begin
            tok.push_back(n);
          end
        end
      end else if (d == 8'h20 || d == 8'h0D || d == 8'h0A) begin
        if (m_bad) m_bad = 1'b0;
        else if (tok.size() > 0) begin
          e.val = '0;
          foreach (tok[i]) e.val = e.val * 16 + W'(tok[i]);
          e.len = tok.size();
          done  = 1'b1;
          tok.delete();
        end
      end else if (!m_bad) begin
        errq.push_back(cyc + 1);
        m_bad = 1'b1;
        tok.delete();
      end
    end
    if (done) begin
      if (!m_held || r) begin
        wq.push_back(e);
        m_held = 1'b1;
      end else begin
        dropq.push_back(cyc + 1);
      end
    end else if (m_held && r) begin
      m_held = 1'b0;
    end
  endtask

  task automatic send(input string s, input bit r);
    for (int i = 0; i < s.len(); i++) step(1'b1, s[i], r);
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, r);
  endtask

  // monitor: samples on the falling edge, between driver updates
  always @(negedge clk) begin
    wexp_t e;
    if (!rst_n) begin
      chk("rst_word_vld", 64'(word_vld), 64'd0);
      chk("rst_word", 64'(word), 64'd0);
      chk("rst_word_len", 64'(word_len), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      chk("rst_drop", 64'(drop), 64'd0);
    end else begin
      if (word_vld && word_rdy) begin
        chk("word_expected", 64'(wq.size() > 0), 64'd1);
        if (wq.size() > 0) begin
          e = wq.pop_front();
          chk("word_value", 64'(word), 64'(e.val));
          chk("word_len", 64'(word_len), 64'(e.len));
        end
      end
      if (err) begin
        chk("err_expected", 64'(errq.size() > 0), 64'd1);
        if (errq.size() > 0) chk("err_cycle", 64'(cyc), 64'(errq.pop_front()));
      end
      if (drop) begin
        chk("drop_expected", 64'(dropq.size() > 0), 64'd1);
        if (dropq.size() > 0) chk("drop_cycle", 64'(cyc), 64'(dropq.pop_front()));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    string hx;
    int    pr, rdy_pct;
    logic [7:0] b;
    hx = "0123456789ABCDEF";

    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    send("1A2B\n", 1'b1);
    send("DEADBEEF\r7 ", 1'b1);
    send("123456789\n5\n", 1'b1);
    send("1G3\n5\n", 1'b1);
    idle(2, 1'b1);
    send("AA\nBB\n", 1'b0);
    idle(3, 1'b0);
    idle(3, 1'b1);
    send("ff\n", 1'b1);
    send("0\n \r\nFFFFFFFF\n", 1'b1);
    idle(2, 1'b1);

    rdy_pct = 50;
    for (int k = 0; k < 3000; k++) begin
      if (k % 200 == 0) rdy_pct = $urandom_range(0, 100);
      pr = $urandom_range(0, 99);
      if (pr < 60)      b = hx[$urandom_range(0, 15)];
      else if (pr < 72) b = 8'h20;
      else if (pr < 77) b = 8'h0A;
      else if (pr < 80) b = 8'h0D;
      else if (pr < 88) b = 8'(8'h61 + $urandom_range(0, 5));
      else              b = 8'($urandom_range(0, 255));
      step($urandom_range(0, 3) != 0, b, $urandom_range(1, 100) <= rdy_pct);
    end
    idle(6, 1'b1);

    // asynchronous reset mid-token with a word held
    send("AA\n12", 1'b0);
    @(posedge clk);
    #1;
    rst_n  = 1'b0;
    rx_vld = 1'b0;
    wq.delete();
    tok.delete();
    m_bad  = 1'b0;
    m_held = 1'b0;
    #2;
    chk("async_rst_word_vld", 64'(word_vld), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send("\n", 1'b1);
    idle(10, 1'b1);

    chk("words_outstanding", 64'(wq.size()), 64'd0);
    chk("errs_outstanding", 64'(errq.size()), 64'd0);
    chk("drops_outstanding", 64'(dropq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
